gpio_input_debouncer: RTL and testbench

//   Conditions the raw switch inputs before they reach the GPIO peripheral's gpio_port_in.
//   - Per bit: 2-flop synchronizer, then a saturating debounce counter.
//   - Outputs a clean level, plus one-cycle rise and fall pulses per bit.
//   - Sits upstream of the SoC top level, in the clk domain used by Heard_Bit.

---
 rtl/gpio_input_debouncer.sv | 101 ++++++++++
 tb/tb_gpio_input_debouncer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_debouncer.sv
// Per-bit switch conditioner: 2-flop synchronizer, saturating debounce counter, edge pulses.
// Optional sticky edge flags with write-1-to-clear and irq when GPIO_IN_STICKY_EN is defined.
module gpio_input_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_COUNTS = 500_000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_raw_in,
  output logic [WIDTH-1:0] gpio_clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed,
  input  logic [WIDTH-1:0] clr_flags,
  output logic [WIDTH-1:0] edge_flags,
  output logic             irq
);

  // Terminal count: the mismatch must persist for DEBOUNCE_COUNTS consecutive cycles.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_COUNTS - 1);

  logic [WIDTH-1:0]            sync1;
  logic [WIDTH-1:0]            sync2;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            clean_d;
  logic [WIDTH-1:0]            rise_d;
  logic [WIDTH-1:0]            fall_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_raw_in;
      sync2 <= sync1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    clean_d = gpio_clean_out;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2[i] != gpio_clean_out[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = sync2[i];
          rise_d[i]  = sync2[i];
          fall_d[i]  = ~sync2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the counters are reset like any other state, so a pending debounce never survives reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q          <= '0;
      gpio_clean_out <= '0;
      rise_pulse     <= '0;
      fall_pulse     <= '0;
      changed        <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      gpio_clean_out <= clean_d;
      rise_pulse     <= rise_d;
      fall_pulse     <= fall_d;
      changed        <= |(rise_d | fall_d);
    end
  end

`ifdef GPIO_IN_STICKY_EN
  logic [WIDTH-1:0] flags_d;

  // Set term comes from the registered pulses and dominates a simultaneous clear.
  assign flags_d = (edge_flags & ~clr_flags) | rise_pulse | fall_pulse;

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_flags <= '0;
      irq        <= 1'b0;
    end else begin
      edge_flags <= flags_d;
      irq        <= |flags_d;
    end
  end
`else
  logic unused_clr_flags;

  assign unused_clr_flags = ^clr_flags;
  assign edge_flags       = '0;
  assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Scoreboard bench for gpio_input_debouncer (WIDTH=8, DEBOUNCE_COUNTS=4); sticky checks
// adapt to whether GPIO_IN_STICKY_EN is defined.
module tb_gpio_input_debouncer;

  localparam int W = 8;
  localparam int N = 4;
`ifdef GPIO_IN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw;
  logic [W-1:0] clean;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;
  logic [W-1:0] clr;
  logic [W-1:0] flags;
  logic         irq;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  gpio_input_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_COUNTS(N),
    .CNT_W          (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gpio_raw_in   (raw),
    .gpio_clean_out(clean),
    .rise_pulse    (rise),
    .fall_pulse    (fall),
    .changed       (changed),
    .clr_flags     (clr),
    .edge_flags    (flags),
    .irq           (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input logic [W-1:0] c, input logic [W-1:0] r,
                              input logic [W-1:0] f, input int at);
    exp_t e;
    e.clean = c;
    e.rise  = r;
    e.fall  = f;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  // Waits at negedges for the monitor to consume every expected event.
  task automatic drain(input string name);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s_timeout: %0d events still pending, expected 0", name, sb.size());
    sb.delete();
  endtask

  task automatic check_flags(input string name, input logic [W-1:0] f_exp);
    check({name, "_flags"}, 32'(flags), STICKY ? 32'(f_exp) : 32'h0);
    check({name, "_irq"}, 32'(irq), STICKY ? 32'(|f_exp) : 32'h0);
  endtask

  task automatic pulse_clr(input logic [W-1:0] v);
    clr = v;
    @(negedge clk);
    clr = '0;
  endtask

  // Monitor: whenever a pulse appears, pop the oldest expectation and compare it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (changed === 1'b1 || |rise === 1'b1 || |fall === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: rise=%0h fall=%0h clean=%0h, expected no event (cycle %0d)",
                   rise, fall, clean, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ev_clean", 32'(clean), 32'(e.clean));
          check("ev_rise", 32'(rise), 32'(e.rise));
          check("ev_fall", 32'(fall), 32'(e.fall));
          check("ev_changed", 32'(changed), 32'h1);
          check("ev_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int c;
    rst = 1'b0;
    raw = '0;
    clr = '0;
    repeat (3) @(negedge clk);
    check("rst_clean", 32'(clean), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);
    check("rst_changed", 32'(changed), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // 1: idle low input
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_clean", 32'(clean), 32'h0);
    check_flags("idle", 8'h00);

    // 2: bit 0 rises after N+2 edges
    c = cyc;
    raw = 8'h01;
    expect_event(8'h01, 8'h01, 8'h00, c + N + 2);
    drain("rise0");
    check("rise0_clean", 32'(clean), 32'h01);
    check("rise0_flags_early", 32'(flags), 32'h0);
    @(negedge clk);
    check_flags("rise0", 8'h01);

    // 3: 3-cycle glitch is rejected
    raw = 8'h00;
    repeat (3) @(negedge clk);
    raw = 8'h01;
    repeat (15) @(negedge clk);
    check("glitch_clean", 32'(clean), 32'h01);

    // 4: multi-bit change
    c = cyc;
    raw = 8'hA5;
    expect_event(8'hA5, 8'hA4, 8'h00, c + N + 2);
    drain("a5");
    check("a5_clean", 32'(clean), 32'hA5);
    @(negedge clk);
    check_flags("a5", 8'hA5);
    pulse_clr(8'hFF);
    check_flags("clr_all1", 8'h00);

    // 5: fall then rise with simultaneous clear
    c = cyc;
    raw = 8'hA4;
    expect_event(8'hA4, 8'h00, 8'h01, c + N + 2);
    drain("fall0");
    check("fall0_clean", 32'(clean), 32'hA4);
    @(negedge clk);
    check_flags("fall0", 8'h01);
    pulse_clr(8'hFF);
    check_flags("clr_all2", 8'h00);

    c = cyc;
    raw = 8'hA5;
    expect_event(8'hA5, 8'h01, 8'h00, c + N + 2);
    drain("rise0b");
    pulse_clr(8'h01);
    check_flags("set_wins", 8'h01);
    pulse_clr(8'hFF);
    check_flags("clr_all3", 8'h00);

    // 6: reset two counts into a pending fall on bit 0
    c = cyc;
    raw = 8'hA4;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_clean", 32'(clean), 32'h0);
    check("midrst_rise", 32'(rise), 32'h0);
    check("midrst_fall", 32'(fall), 32'h0);
    check("midrst_changed", 32'(changed), 32'h0);
    check_flags("midrst", 8'h00);
    rst = 1'b1;
    c = cyc;
    expect_event(8'hA4, 8'hA4, 8'h00, c + N + 2);
    drain("post_rst");
    check("post_rst_clean", 32'(clean), 32'hA4);
    repeat (10) @(negedge clk);
    check("final_clean", 32'(clean), 32'hA4);
    check("final_pending", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
